// File: rtl/wb_grf_stage_pkg.sv
// wb_grf_stage_pkg: load-type, write-back-select and reset constants shared by the WB stage
package wb_grf_stage_pkg;
    localparam logic [2:0]  DM_LW    = 3'd0;
    localparam logic [2:0]  DM_LBU   = 3'd1;
    localparam logic [2:0]  DM_LB    = 3'd2;
    localparam logic [2:0]  DM_LHU   = 3'd3;
    localparam logic [2:0]  DM_LH    = 3'd4;
    localparam logic [1:0]  WB_AO    = 2'd0;
    localparam logic [1:0]  WB_DR    = 2'd1;
    localparam logic [1:0]  WB_PC8   = 2'd2;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/wb_grf_stage_load_ext.sv
// wb_grf_stage_load_ext: byte/halfword extraction and zero/sign extension of a loaded word
// ports: dr_i raw memory word, off_i byte offset, op_i load type, data_o extended result
module wb_grf_stage_load_ext
    import wb_grf_stage_pkg::*;
(
    input  logic [31:0] dr_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b      = 8'(dr_i >> {off_i, 3'b000});
        h      = off_i[1] ? dr_i[31:16] : dr_i[15:0];
        data_o = (op_i == DM_LW)  ? dr_i :
                 (op_i == DM_LBU) ? {24'b0, b} :
                 (op_i == DM_LB)  ? {{24{b[7]}}, b} :
                 (op_i == DM_LHU) ? {16'b0, h} :
                 (op_i == DM_LH)  ? {{16{h[15]}}, h} : dr_i;
    end
endmodule

// File: rtl/wb_grf_stage.sv
// wb_grf_stage: write-back select and commit into the register file, with bypassed reads and commit trace
// ports: clk/reset; W_* WB-stage bundle; rs/rt read ports; W_wdata forwarding value; commit_* trace
module wb_grf_stage
    import wb_grf_stage_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       W_WR,
    input  logic [31:0]      W_DR,
    input  logic [31:0]      W_AO,
    input  logic [31:0]      W_pc,
    input  logic [31:0]      W_pc_add_8,
    input  logic             RegWrite_W,
    input  logic [1:0]       MemtoReg_W,
    input  logic [2:0]       DMOp_W,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      W_wdata,
    output logic             commit_valid,
    output logic [31:0]      commit_pc,
    output logic [4:0]       commit_reg,
    output logic [31:0]      commit_data,
    output logic [CNT_W-1:0] commit_cnt
);
    logic [31:0]      regs_q [NREG];
    logic [31:0]      ld_data;
    logic             we;
    logic             valid_q;
    logic [31:0]      pc_q;
    logic [4:0]       reg_q;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    wb_grf_stage_load_ext u_load_ext (
        .dr_i   (W_DR),
        .off_i  (W_AO[1:0]),
        .op_i   (DMOp_W),
        .data_o (ld_data)
    );

    // reads bypass the value being written this cycle so the D stage never sees a stale register
    always_comb begin
        we      = RegWrite_W && (W_WR != 5'd0) && !reset;
        W_wdata = (MemtoReg_W == WB_AO)  ? W_AO :
                  (MemtoReg_W == WB_DR)  ? ld_data :
                  (MemtoReg_W == WB_PC8) ? W_pc_add_8 : 32'd0;
        rs_data = (rs_addr == 5'd0) ? 32'd0 : (we && rs_addr == W_WR) ? W_wdata : regs_q[rs_addr];
        rt_data = (rt_addr == 5'd0) ? 32'd0 : (we && rt_addr == W_WR) ? W_wdata : regs_q[rt_addr];
        cnt_d   = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[W_WR] <= W_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            reg_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= we;
            if (we) begin
                pc_q   <= W_pc;
                reg_q  <= W_WR;
                data_q <= W_wdata;
                cnt_q  <= cnt_d;
            end
        end
    end

    assign commit_valid = valid_q;
    assign commit_pc    = pc_q;
    assign commit_reg   = reg_q;
    assign commit_data  = data_q;
    assign commit_cnt   = cnt_q;
endmodule

// File: tb/tb_wb_grf_stage.sv
// tb_wb_grf_stage: randomized scoreboard bench for the WB stage register file and commit trace
module tb_wb_grf_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  W_WR = '0, rs_addr = '0, rt_addr = '0;
    logic [31:0] W_DR = '0, W_AO = '0, W_pc = '0, W_pc_add_8 = '0;
    logic        RegWrite_W = 1'b0;
    logic [1:0]  MemtoReg_W = '0;
    logic [2:0]  DMOp_W = '0;
    logic [31:0] rs_data, rt_data, W_wdata, commit_pc, commit_data, commit_cnt;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [31:0] rs4, rt4, wd4, cpc4, cdata4;
    logic        cv4;
    logic [4:0]  creg4;
    logic [3:0]  cnt4;

    wb_grf_stage dut (
        .clk(clk), .reset(reset), .W_WR(W_WR), .W_DR(W_DR), .W_AO(W_AO), .W_pc(W_pc),
        .W_pc_add_8(W_pc_add_8), .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .DMOp_W(DMOp_W),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .W_wdata(W_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_reg(commit_reg),
        .commit_data(commit_data), .commit_cnt(commit_cnt)
    );

    wb_grf_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .W_WR(W_WR), .W_DR(W_DR), .W_AO(W_AO), .W_pc(W_pc),
        .W_pc_add_8(W_pc_add_8), .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .DMOp_W(DMOp_W),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs4), .rt_data(rt4), .W_wdata(wd4),
        .commit_valid(cv4), .commit_pc(cpc4), .commit_reg(creg4),
        .commit_data(cdata4), .commit_cnt(cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] cnt;
    } commit_t;

    commit_t     sb[$];
    commit_t     mon_e;
    logic [31:0] model_rf [32];
    logic [31:0] mdl_cnt;
    int          checks = 0, failures = 0, pulses = 0, p0;

    logic [2:0]  lop  [6] = '{3'd2, 3'd2, 3'd1, 3'd4, 3'd3, 3'd6};
    logic [1:0]  lao  [6] = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] lexp [6] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080,
                              32'hFFFF80F1, 32'h00007F02, 32'h80F17F02};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_wdata(input logic [1:0] m2r, input logic [2:0] op,
                                              input logic [31:0] dr, input logic [31:0] ao,
                                              input logic [31:0] pc8);
        logic [31:0] b, h, ld;
        b = (dr >> (8 * ao[1:0])) & 32'hFF;
        h = (dr >> (16 * ao[1])) & 32'hFFFF;
        case (op)
            3'd1:    ld = b;
            3'd2:    ld = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd3:    ld = h;
            3'd4:    ld = (h >= 32768) ? h + 32'hFFFF0000 : h;
            default: ld = dr;
        endcase
        case (m2r)
            2'd0:    return ao;
            2'd1:    return ld;
            2'd2:    return pc8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_rd(input logic [4:0] a, input bit w, input logic [4:0] wr,
                                           input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (w && a == wr) return wd;
        return model_rf[a];
    endfunction

    task automatic step(input bit rst, input bit rw, input logic [4:0] wr, input logic [31:0] dr,
                        input logic [31:0] ao, input logic [31:0] pc, input logic [31:0] pc8,
                        input logic [1:0] m2r, input logic [2:0] op,
                        input logic [4:0] ra, input logic [4:0] rb);
        logic [31:0] ew;
        bit ewe;
        @(negedge clk);
        reset = rst; RegWrite_W = rw; W_WR = wr; W_DR = dr; W_AO = ao; W_pc = pc;
        W_pc_add_8 = pc8; MemtoReg_W = m2r; DMOp_W = op; rs_addr = ra; rt_addr = rb;
        ew  = ref_wdata(m2r, op, dr, ao, pc8);
        ewe = rw && wr != 0 && !rst;
        #1;
        chk("wdata", W_wdata, ew);
        chk("rs_data", rs_data, ref_rd(ra, ewe, wr, ew));
        chk("rt_data", rt_data, ref_rd(rb, ewe, wr, ew));
        if (ewe) begin
            mdl_cnt = mdl_cnt + 1;
            sb.push_back('{pc: pc, rd: wr, data: ew, cnt: mdl_cnt});
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] = '0;
            mdl_cnt = '0;
        end else if (ewe) begin
            model_rf[wr] = ew;
        end
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 3'd0, ra, rb);
    endtask

    always @(negedge clk) begin
        if (commit_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit: got commit of reg %0d expected no commit", commit_reg);
            end else begin
                mon_e = sb.pop_front();
                chk("commit_pc", commit_pc, mon_e.pc);
                chk("commit_reg", {27'b0, commit_reg}, {27'b0, mon_e.rd});
                chk("commit_data", commit_data, mon_e.data);
                chk("commit_cnt", commit_cnt, mon_e.cnt);
                chk("commit_cnt4", {28'b0, cnt4}, mon_e.cnt & 32'hF);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        mdl_cnt = '0;
        repeat (2) step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 3'd0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            idle(5'(i), 5'(32 - i));
            chk("rst_rs", rs_data, 32'd0);
            if (i == 1) begin
                chk("rst_valid", {31'b0, commit_valid}, 32'd0);
                chk("rst_cnt", commit_cnt, 32'd0);
                chk("rst_pc", commit_pc, 32'h3000);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 5'd8, 32'h80F17F02, {30'b0, lao[i]}, 32'h3100, 32'h3108, 2'd1, lop[i], 5'd8, 5'd0);
            chk("ld_const", W_wdata, lexp[i]);
        end
        step(1'b0, 1'b1, 5'd5, 32'd0, 32'h1234, 32'h3200, 32'h3208, 2'd0, 3'd0, 5'd5, 5'd5);
        chk("byp_rs", rs_data, 32'h1234);
        chk("byp_rt", rt_data, 32'h1234);
        idle(5'd5, 5'd0);
        chk("reg5", rs_data, 32'h1234);
        step(1'b0, 1'b1, 5'd0, 32'd0, 32'hDEAD, 32'h3300, 32'h3308, 2'd0, 3'd0, 5'd0, 5'd0);
        chk("r0", rs_data, 32'd0);
        step(1'b0, 1'b1, 5'd31, 32'd0, 32'd0, 32'h3008, 32'h3010, 2'd2, 3'd0, 5'd0, 5'd0);
        idle(5'd31, 5'd31);
        chk("reg31", rs_data, 32'h3010);
        chk("jal_pc", commit_pc, 32'h3008);
        chk("cnt_r0_skip", commit_cnt, 32'd8);
        step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 3'd0, 5'd0, 5'd0);
        p0 = pulses;
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b1, 5'((i % 31) + 1), $urandom, $urandom, $urandom, $urandom,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom));
        idle(5'd0, 5'd0);
        chk("stream_pulses", pulses - p0, 32'd40);
        chk("stream_cnt", commit_cnt, 32'd40);
        chk("wrap_cnt4", {28'b0, cnt4}, 32'd8);
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom));
        step(1'b0, 1'b1, 5'd9, 32'd0, 32'h9999, 32'h3400, 32'h3408, 2'd0, 3'd0, 5'd9, 5'd0);
        step(1'b1, 1'b1, 5'd9, 32'd0, 32'h5555, 32'h3500, 32'h3508, 2'd0, 3'd0, 5'd0, 5'd0);
        idle(5'd9, 5'd9);
        chk("rst_mid_reg9", rs_data, 32'd0);
        chk("rst_mid_valid", {31'b0, commit_valid}, 32'd0);
        chk("rst_mid_cnt", commit_cnt, 32'd0);
        idle(5'd0, 5'd0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
